// File: rtl/body_collision_check.sv
`default_nettype none
// ============================================================================
// Module   : body_collision_check
// Desc     : Per-tick collision/eat checker. Tests the proposed head against
//            the playfield walls and the apple when a tick starts, then scans
//            the body one segment per cycle with a single 8-bit comparator.
//            Optional macro COLLISION_WRAP_EN: torus playfield (no walls).
// Revision : 1.0 - initial release
// ============================================================================
module body_collision_check #(
  parameter int         MAX_LENGTH = 50,
  parameter logic [3:0] X_MIN      = 4'd1,
  parameter logic [3:0] X_MAX      = 4'd14,
  parameter logic [3:0] Y_MIN      = 4'd1,
  parameter logic [3:0] Y_MAX      = 4'd10
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sync_i,
  input  logic                       start_i,
  input  logic [7:0]                 head_i,
  input  logic [MAX_LENGTH-1:0][7:0] body_i,
  input  logic [7:0]                 curr_length_i,
  input  logic [7:0]                 apple_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       collide_o,
  output logic                       eat_o
);

  localparam int            IW       = (MAX_LENGTH > 1) ? $clog2(MAX_LENGTH) : 1;
  localparam int            LW       = $clog2(MAX_LENGTH + 1);
  localparam logic [7:0]    MAX_LEN8 = 8'(MAX_LENGTH);
  localparam logic [LW-1:0] MAX_LENW = LW'(MAX_LENGTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [LW-1:0] len_q, len_d;
  logic [7:0]    head_q, head_d;
  logic          collide_q, collide_d;
  logic          eat_q, eat_d;
  logic          busy_q, done_q;

  logic          w_wall;
  logic [LW-1:0] w_len;
  logic          w_idx_last;
  logic          w_seg_hit;

`ifdef COLLISION_WRAP_EN
  // Torus playfield: coordinates wrap in 4 bits, so no head is ever off-field.
  assign w_wall = 1'b0;
`else
  assign w_wall = (head_i[7:4] < X_MIN) | (head_i[7:4] > X_MAX) |
                  (head_i[3:0] < Y_MIN) | (head_i[3:0] > Y_MAX);
`endif

  // Clamp the occupied count so the scan never indexes past the array.
  assign w_len      = (curr_length_i > MAX_LEN8) ? MAX_LENW : curr_length_i[LW-1:0];
  // idx+1 cannot overflow LW bits because idx stays below len during a scan.
  assign w_idx_last = ((LW'(idx_q) + LW'(1)) == len_q);
  assign w_seg_hit  = (body_i[idx_q] == head_q);

  // Next-state, scan index and result latches.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    len_d     = len_q;
    head_d    = head_q;
    collide_d = collide_q;
    eat_d     = eat_q;
    if (sync_i) begin
      state_d   = S_IDLE;
      idx_d     = '0;
      collide_d = 1'b0;
      eat_d     = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            head_d    = head_i;
            len_d     = w_len;
            collide_d = w_wall;
            eat_d     = (head_i == apple_i) & ~w_wall;
            if (w_wall || (w_len <= LW'(1))) begin
              state_d = S_DONE;
            end else begin
              idx_d   = IW'(1);
              state_d = S_SCAN;
            end
          end
        end
        S_SCAN: begin
          // Entry 0 is the old head and is skipped by starting idx at 1.
          if (w_seg_hit) begin
            collide_d = 1'b1;
            eat_d     = 1'b0;
            state_d   = S_DONE;
          end else if (w_idx_last) begin
            state_d = S_DONE;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers; busy/done are registered decodes of next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      len_q     <= '0;
      head_q    <= '0;
      collide_q <= 1'b0;
      eat_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      len_q     <= len_d;
      head_q    <= head_d;
      collide_q <= collide_d;
      eat_q     <= eat_d;
      busy_q    <= (state_d != S_IDLE);
      done_q    <= (state_d == S_DONE);
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign collide_o = collide_q;
  assign eat_o     = eat_q;

endmodule
`default_nettype wire
